// File: rtl/fc_layer_gen.sv
// Fully-connected layer engine: streams the input vector, weights and biases from DRAM
// through a valid handshake, accumulates saturating fixed-point products, applies optional ReLU.
module fc_layer_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int IN_SIZE    = 400,
  parameter int OUT_SIZE   = 120,
  parameter int FRAC_BITS  = 16,
  parameter int WT_BASE    = 0,
  parameter int BS_BASE    = 48000,
  parameter int IFMAP_BASE = 65536,
  parameter int OFMAP_BASE = 131072,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [IW-1:0]         I_LAST     = IW'(IN_SIZE - 1);
  localparam logic [OW-1:0]         O_LAST     = OW'(OUT_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] WT_ADDR    = ADDR_WIDTH'(WT_BASE);
  localparam logic [ADDR_WIDTH-1:0] BS_ADDR    = ADDR_WIDTH'(BS_BASE);
  localparam logic [ADDR_WIDTH-1:0] IFMAP_ADDR = ADDR_WIDTH'(IFMAP_BASE);
  localparam logic [ADDR_WIDTH-1:0] OFMAP_ADDR = ADDR_WIDTH'(OFMAP_BASE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_IFMAP = 3'd1,
    MAC      = 3'd2,
    BIAS     = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Clamp a double-width signed value into the DATA_WIDTH signed range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] max_v;
    logic signed [PW-1:0] min_v;
    max_v = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    min_v = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (x > max_v) sat_fn = max_v[DATA_WIDTH-1:0];
    else if (x < min_v) sat_fn = min_v[DATA_WIDTH-1:0];
    else sat_fn = x[DATA_WIDTH-1:0];
  endfunction

  state_t                         state_r, state_s;
  logic [IW-1:0]                  i_r, i_s;
  logic [OW-1:0]                  o_r, o_s;
  logic signed [DATA_WIDTH-1:0]   acc_r, acc_s;
  logic [ADDR_WIDTH-1:0]          wt_ptr_r, wt_ptr_s;
  logic [DATA_WIDTH-1:0]          data_out_s;
  logic [ADDR_WIDTH-1:0]          addr_out_s, addr_in_s;
  logic                           rd_en_s, ifmap_we_s;
  logic signed [DATA_WIDTH-1:0]   ifmap_r [IN_SIZE];
  logic signed [PW-1:0]           prod_s;
  logic signed [DATA_WIDTH-1:0]   prod_sat_s, mac_sum_s, bias_sum_s, act_s;

  // Datapath: Q-format product, saturating accumulate, bias add and activation.
  always_comb begin
    prod_s     = PW'($signed(data_in)) * PW'(ifmap_r[i_r]);
    prod_sat_s = sat_fn(prod_s >>> FRAC_BITS);
    mac_sum_s  = sat_fn(PW'(acc_r) + PW'(prod_sat_s));
    bias_sum_s = sat_fn(PW'(acc_r) + PW'($signed(data_in)));
    if (RELU_EN && bias_sum_s[DATA_WIDTH-1]) act_s = {DATA_WIDTH{1'b0}};
    else act_s = bias_sum_s;
  end

  // Next-state logic; every counter and the accumulator move only on an accepted read.
  always_comb begin
    state_s    = state_r;
    i_s        = i_r;
    o_s        = o_r;
    acc_s      = acc_r;
    wt_ptr_s   = wt_ptr_r;
    data_out_s = data_out;
    addr_out_s = addr_out;
    ifmap_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s  = LD_IFMAP;
          i_s      = {IW{1'b0}};
          o_s      = {OW{1'b0}};
          acc_s    = {DATA_WIDTH{1'b0}};
          wt_ptr_s = WT_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      LD_IFMAP: begin
        if (dram_valid) begin
          ifmap_we_s = 1'b1;
          if (i_r == I_LAST) begin
            i_s     = {IW{1'b0}};
            state_s = MAC;
          end else begin
            i_s = i_r + IW'(1'b1);
          end
        end else begin
          state_s = LD_IFMAP;
        end
      end
      MAC: begin
        if (dram_valid) begin
          acc_s    = mac_sum_s;
          wt_ptr_s = wt_ptr_r + ADDR_WIDTH'(1'b1);
          if (i_r == I_LAST) begin
            i_s     = {IW{1'b0}};
            state_s = BIAS;
          end else begin
            i_s = i_r + IW'(1'b1);
          end
        end else begin
          state_s = MAC;
        end
      end
      BIAS: begin
        if (dram_valid) begin
          data_out_s = act_s;
          acc_s      = {DATA_WIDTH{1'b0}};
          addr_out_s = OFMAP_ADDR + ADDR_WIDTH'(o_r);
          state_s    = WRITE;
        end else begin
          state_s = BIAS;
        end
      end
      WRITE: begin
        if (o_r == O_LAST) begin
          state_s = DONE;
        end else begin
          o_s     = o_r + OW'(1'b1);
          state_s = MAC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    rd_en_s = (state_s == LD_IFMAP) || (state_s == MAC) || (state_s == BIAS);
    case (state_s)
      LD_IFMAP: addr_in_s = IFMAP_ADDR + ADDR_WIDTH'(i_s);
      MAC:      addr_in_s = wt_ptr_s;
      BIAS:     addr_in_s = BS_ADDR + ADDR_WIDTH'(o_s);
      default:  addr_in_s = {ADDR_WIDTH{1'b0}};
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r    <= IDLE;
      i_r        <= {IW{1'b0}};
      o_r        <= {OW{1'b0}};
      acc_r      <= {DATA_WIDTH{1'b0}};
      wt_ptr_r   <= WT_ADDR;
      data_out   <= {DATA_WIDTH{1'b0}};
      addr_out   <= OFMAP_ADDR;
      addr_in    <= {ADDR_WIDTH{1'b0}};
      dram_en_rd <= 1'b0;
      dram_en_wr <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      i_r        <= i_s;
      o_r        <= o_s;
      acc_r      <= acc_s;
      wt_ptr_r   <= wt_ptr_s;
      data_out   <= data_out_s;
      addr_out   <= addr_out_s;
      addr_in    <= addr_in_s;
      dram_en_rd <= rd_en_s;
      dram_en_wr <= (state_s == WRITE);
      busy       <= (state_s != IDLE);
      done       <= (state_s == DONE);
    end
  end

  // Input-vector buffer; contents are only meaningful during a layer, so no reset.
  always_ff @(posedge clk) begin
    if (ifmap_we_s) ifmap_r[i_r] <= $signed(data_in);
  end

endmodule

// File: tb/tb_fc_layer_gen.sv
// Bench for fc_layer_gen: a DRAM model serves reads, a vector-level reference model
// predicts outputs, handshake timing and completion latency for two ReLU settings.
module tb_fc_layer_gen;
  localparam int DW  = 32;
  localparam int AW  = 18;
  localparam int NI  = 4;
  localparam int NO  = 3;
  localparam int WTB = 0;
  localparam int BSB = 48000;
  localparam int IFB = 65536;
  localparam int OFB = 131072;
  localparam int BASE_EDGES = NI + NO * (NI + 2);

  logic          clk = 1'b0;
  logic          arst, enable, dram_valid;
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout1, dout0;
  logic [AW-1:0] ain1, ain0, aout1, aout0;
  logic          rd1, rd0, wr1, wr0, busy1, busy0, done1, done0;

  logic [31:0] ifm [NI];
  logic [31:0] wt  [NI*NO];
  logic [31:0] bs  [NO];
  logic [31:0] exp1 [NO];
  logic [31:0] exp0 [NO];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_layer_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_SIZE(NI), .OUT_SIZE(NO), .FRAC_BITS(16),
    .WT_BASE(WTB), .BS_BASE(BSB), .IFMAP_BASE(IFB), .OFMAP_BASE(OFB), .RELU_EN(1'b1)) dut_relu (
    .clk(clk), .arst(arst), .enable(enable), .dram_valid(dram_valid), .data_in(data_in),
    .data_out(dout1), .addr_in(ain1), .addr_out(aout1), .dram_en_rd(rd1), .dram_en_wr(wr1),
    .busy(busy1), .done(done1));

  fc_layer_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IN_SIZE(NI), .OUT_SIZE(NO), .FRAC_BITS(16),
    .WT_BASE(WTB), .BS_BASE(BSB), .IFMAP_BASE(IFB), .OFMAP_BASE(OFB), .RELU_EN(1'b0)) dut_lin (
    .clk(clk), .arst(arst), .enable(enable), .dram_valid(dram_valid), .data_in(data_in),
    .data_out(dout0), .addr_in(ain0), .addr_out(aout0), .dram_en_rd(rd0), .dram_en_wr(wr0),
    .busy(busy0), .done(done0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > 64'sd2147483647) return 64'sd2147483647;
    else if (x < -64'sd2147483648) return -64'sd2147483648;
    else return x;
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned a);
    if (a >= IFB && a < IFB + NI) return ifm[a - IFB];
    else if (a < WTB + NI * NO) return wt[a - WTB];
    else if (a >= BSB && a < BSB + NO) return bs[a - BSB];
    else return 32'h0;
  endfunction

  // Reference: y[o] = f(sat(sum_i sat((w*x)>>16) + b[o])) with saturation after every add.
  task automatic compute_exp();
    longint acc, p, r;
    for (int o = 0; o < NO; o++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) begin
        p = longint'($signed(wt[o*NI+i])) * longint'($signed(ifm[i]));
        p = sat(p >>> 16);
        acc = sat(acc + p);
      end
      r = sat(acc + longint'($signed(bs[o])));
      exp0[o] = r[31:0];
      exp1[o] = (r < 0) ? 32'h0 : r[31:0];
    end
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < NI; i++) begin
      case (kind)
        0, 1:    ifm[i] = 32'h0001_0000;
        2:       ifm[i] = 32'h7FFF_0000;
        default: ifm[i] = $urandom() >> $urandom_range(0, 14);
      endcase
    end
    for (int k = 0; k < NI * NO; k++) begin
      case (kind)
        0:       wt[k] = 32'h0000_8000;
        1:       wt[k] = 32'hFFFF_0000;
        2:       wt[k] = 32'h7FFF_0000;
        default: wt[k] = $urandom() >> $urandom_range(0, 14);
      endcase
    end
    for (int o = 0; o < NO; o++) begin
      case (kind)
        0:       bs[o] = 32'h0;
        1:       bs[o] = 32'h0001_0000;
        2:       bs[o] = 32'h7FFF_0000;
        default: bs[o] = $urandom() >> $urandom_range(0, 12);
      endcase
    end
    compute_exp();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dout1"}, dout1, 64'h0);
    check({tag, "_dout0"}, dout0, 64'h0);
    check({tag, "_aout"}, aout1, OFB);
    check({tag, "_ain"}, {ain1, ain0}, 64'h0);
    check({tag, "_ctl"}, {rd1, wr1, busy1, done1, rd0, wr0, busy0, done0}, 64'h0);
  endtask

  // vmode: 0 valid always, 1 valid one cycle in three, 2 random valid.
  task automatic run_layer(input int vmode, input bit inj, input bit abort);
    int unsigned q[$];
    int  stalls = 0, widx = 0, edge_n = 0, exp_now;
    bit  wr_exp = 1'b0, rd_exp, v;
    for (int i = 0; i < NI; i++) q.push_back(IFB + i);
    for (int o = 0; o < NO; o++) begin
      for (int i = 0; i < NI; i++) q.push_back(WTB + o * NI + i);
      q.push_back(BSB + o);
    end
    exp_now = BASE_EDGES;
    @(negedge clk); enable = 1'b1; dram_valid = 1'b0;
    @(negedge clk); enable = 1'b0;
    while (edge_n <= exp_now + 1 && edge_n < 600) begin
      exp_now = BASE_EDGES + stalls;
      rd_exp  = (q.size() > 0) && !wr_exp;
      check("busy", {busy1, busy0}, {2{edge_n <= exp_now}});
      check("done", {done1, done0}, {2{edge_n == exp_now}});
      check("rd_en", {rd1, rd0}, {2{rd_exp}});
      check("wr_en", {wr1, wr0}, {2{wr_exp}});
      if (rd_exp) begin
        check("rd_addr", ain1, q[0]);
        check("rd_addr0", ain0, q[0]);
      end else begin
        check("rd_addr_idle", {ain1, ain0}, 64'h0);
      end
      if (wr_exp) begin
        check("wr_addr", {aout1, aout0}, {AW'(OFB + widx), AW'(OFB + widx)});
        check("wr_data_relu", dout1, exp1[widx]);
        check("wr_data_lin", dout0, exp0[widx]);
        widx++;
      end
      if (abort && widx == 1 && rd_exp && q[0] >= WTB + NI && q[0] < WTB + 2 * NI) begin
        arst = 1'b1;
        #1 check_reset("arst_mid");
        @(negedge clk); arst = 1'b0; dram_valid = 1'b1;
        repeat (8) begin
          @(negedge clk);
          check("post_arst_idle", {wr1, wr0, rd1, busy1, done1}, 64'h0);
        end
        return;
      end
      wr_exp = 1'b0;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (edge_n % 3 == 2);
        default: v = 1'($urandom_range(0, 1));
      endcase
      dram_valid = v;
      data_in    = rd_exp ? mem_rd(q[0]) : $urandom();
      if (rd_exp) begin
        if (v) begin
          if (q[0] >= BSB && q[0] < BSB + NO) wr_exp = 1'b1;
          void'(q.pop_front());
        end else begin
          stalls++;
        end
      end
      enable = inj && (edge_n == 8);
      @(negedge clk);
      edge_n++;
    end
    check("in_budget", edge_n < 600, 1'b1);
    check("n_writes", widx, NO);
    check("reads_left", q.size(), 0);
  endtask

  initial begin
    arst = 1'b1; enable = 1'b0; dram_valid = 1'b0; data_in = 32'h0;
    #1 check_reset("por");
    @(negedge clk); @(negedge clk); arst = 1'b0;
    @(negedge clk); check_reset("idle");
    load(0); run_layer(0, 1'b0, 1'b0);
    load(1); run_layer(0, 1'b0, 1'b0);
    load(2); run_layer(0, 1'b0, 1'b0);
    load(0); run_layer(1, 1'b0, 1'b0);
    load(0); run_layer(0, 1'b1, 1'b0);
    repeat (6) begin
      load(3); run_layer(2, 1'b0, 1'b0);
    end
    load(0); run_layer(0, 1'b0, 1'b1);
    load(0); run_layer(0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_gen.md
FC_LAYER_GEN -- requirements
Module: fc_layer_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of data_in/data_out, signed fixed point.
REQ-002 SHALL have parameter ADDR_WIDTH, default 18, DRAM address width.
REQ-003 SHALL have parameter IN_SIZE, default 400, input vector length (>=1).
REQ-004 SHALL have parameter OUT_SIZE, default 120, output neuron count (>=1).
REQ-005 SHALL have parameter FRAC_BITS, default 16, fractional bits of every operand.
REQ-006 SHALL have parameters WT_BASE=0, BS_BASE=48000, IFMAP_BASE=65536, OFMAP_BASE=131072, base addresses of weights, biases, input vector and output vector.
REQ-007 SHALL have parameter RELU_EN, default 1, 1 = ReLU applied to outputs, 0 = bypass.
REQ-008 SHALL have ports: clk input 1 clock; arst input 1 reset, asynchronous, active-high; enable input 1 start request; dram_valid input 1 read data valid; data_in input DATA_WIDTH read data; data_out output DATA_WIDTH write data; addr_in output ADDR_WIDTH read address; addr_out output ADDR_WIDTH write address; dram_en_rd output 1 read request; dram_en_wr output 1 write strobe; busy output 1 layer in progress; done output 1 completion pulse.

Function
REQ-009 SHALL implement states IDLE, LD_IFMAP, MAC, BIAS, WRITE, DONE.
REQ-010 SHALL leave IDLE for LD_IFMAP on a clock edge with enable=1; enable outside IDLE SHALL be ignored.
REQ-011 Read handshake: in LD_IFMAP, MAC, BIAS, dram_en_rd=1 and addr_in held constant until a cycle with dram_valid=1; data_in consumed that cycle; address/counters advance only then.
REQ-012 dram_valid=0 SHALL stall: no counter, accumulator or state change.
REQ-013 LD_IFMAP reads IFMAP_BASE+i, i=0..IN_SIZE-1, into internal buffer ifmap[i]; after last word go to MAC with o=0.
REQ-014 MAC reads WT_BASE+o*IN_SIZE+i; per accepted word acc <= sat(acc + ((data_in*ifmap[i]) >>> FRAC_BITS)); product computed at 2*DATA_WIDTH signed, arithmetic shift, then saturation to DATA_WIDTH signed range; after i=IN_SIZE-1 go to BIAS.
REQ-015 Weight address SHALL be generated by an incrementing pointer (no multiplier); addresses wrap modulo 2^ADDR_WIDTH.
REQ-016 BIAS reads BS_BASE+o; on accept data_out <= f(sat(acc+bias)), f = ReLU (negative -> 0) if RELU_EN else identity; acc cleared to 0; go to WRITE.
REQ-017 WRITE lasts exactly one cycle: dram_en_wr=1, addr_out=OFMAP_BASE+o, data_out stable; then o+1 and MAC, or DONE if o=OUT_SIZE-1.
REQ-018 DONE lasts one cycle with done=1, then IDLE; ifmap buffer contents unspecified after completion.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 dram_en_rd=0 and dram_en_wr=0 in IDLE, WRITE (rd), DONE; addr_in=0 when dram_en_rd=0.
REQ-021 With dram_valid tied 1, DONE SHALL be entered IN_SIZE+OUT_SIZE*(IN_SIZE+2) edges after the enable-sampling edge.
REQ-022 Saturation bounds: +2^(DATA_WIDTH-1)-1, -2^(DATA_WIDTH-1); applied at product, accumulate and bias add.

Reset
REQ-023 arst=1 SHALL immediately force IDLE, acc=0, all counters 0, data_out=0, addr_out=OFMAP_BASE, addr_in=0, dram_en_rd=0, dram_en_wr=0, busy=0, done=0.
REQ-024 Reset mid-operation SHALL abandon the layer; no write strobe after reset assertion; next enable starts a fresh layer.
REQ-025 ifmap buffer SHALL not require reset.

Verification (IN_SIZE=4, OUT_SIZE=3, FRAC_BITS=16 unless stated)
REQ-026 ifmap all 0x00010000, weights 0x00008000, bias 0, dram_valid=1 -> three writes of 0x00020000 to OFMAP_BASE+0..2; done entered 22 edges after enable edge.
REQ-027 weights 0xFFFF0000 (-1.0), ifmap 1.0, bias 0x00010000 -> RELU_EN=1 writes 0x00000000; RELU_EN=0 writes 0xFFFD0000.
REQ-028 ifmap 0x7FFF0000, weights 0x7FFF0000, bias 0x7FFF0000 -> every output 0x7FFFFFFF (positive saturation), no wrap.
REQ-029 dram_valid high 1 cycle in 3 -> same data as REQ-026; addr_in constant during every stall; done delayed accordingly.
REQ-030 arst pulsed during MAC of o=1 -> outputs reset values within same cycle, no further dram_en_wr; re-enable reproduces REQ-026 exactly.
REQ-031 enable pulsed during MAC -> ignored, single done pulse, exactly OUT_SIZE writes.
